// File: rtl/sample_tx_pkg.sv
// Shared types and constants for the sample memory to UART TX sequencer.
// FSM state encoding, address-counter opcodes and byte-split widths.
package sample_tx_pkg;

  localparam int BYTE_W  = 8;
  localparam int SPLIT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_LATCH   = 3'd2,
    ST_SEND_HI = 3'd3,
    ST_SEND_LO = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_CLEAR = 2'd1,
    OP_INC   = 2'd2
  } addr_op_e;

endpackage

// File: rtl/tx_addr_counter.sv
// Sample-memory read address register with clear/hold/increment opcode.
// last_o flags the final address so the run ends without wrapping.
module tx_addr_counter
  import sample_tx_pkg::*;
#(
  parameter int AddrWidth = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  addr_op_e             op_i,
  output logic [AddrWidth-1:0] addr_o,
  output logic                 last_o
);

  logic [AddrWidth-1:0] addr_d;
  logic [AddrWidth-1:0] addr_q;

  always_comb begin
    addr_d = addr_q;
    unique case (op_i)
      OP_CLEAR: addr_d = '0;
      OP_INC:   addr_d = addr_q + AddrWidth'(1);
      default:  addr_d = addr_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = &addr_q;

endmodule

// File: rtl/sample_tx_sequencer.sv
// Walks the captured-sample memory and streams each sample as two bytes,
// MSB first, over a valid/ready handshake; pulses done after the last byte.
module sample_tx_sequencer
  import sample_tx_pkg::*;
#(
  parameter int AddrWidth = 5,
  parameter int DataWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 mem_rd_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  input  logic [DataWidth-1:0] mem_data_i,
  output logic [BYTE_W-1:0]    tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic                 busy_o,
  output logic                 done_o
);

  state_e              state_d;
  state_e              state_q;
  logic [SPLIT_W-1:0]  sample_d;
  logic [SPLIT_W-1:0]  sample_q;
  logic                mem_rd_d;
  logic                mem_rd_q;
  logic [BYTE_W-1:0]   tx_data_d;
  logic [BYTE_W-1:0]   tx_data_q;
  logic                tx_valid_d;
  logic                tx_valid_q;
  logic                busy_d;
  logic                busy_q;
  logic                done_d;
  logic                done_q;
  addr_op_e            addr_op;
  logic                addr_last;

  tx_addr_counter #(
    .AddrWidth (AddrWidth)
  ) u_addr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .op_i   (addr_op),
    .addr_o (mem_addr_o),
    .last_o (addr_last)
  );

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    addr_op  = OP_HOLD;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_READ;
          addr_op = OP_CLEAR;
        end
      end
      ST_READ: state_d = ST_LATCH;
      ST_LATCH: begin
        sample_d = SPLIT_W'(mem_data_i);
        state_d  = ST_SEND_HI;
      end
      ST_SEND_HI: begin
        if (tx_ready_i) state_d = ST_SEND_LO;
      end
      ST_SEND_LO: begin
        if (tx_ready_i) begin
          if (addr_last) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_READ;
            addr_op = OP_INC;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops aligned
  // with the state they belong to.
  always_comb begin
    mem_rd_d   = (state_d == ST_READ);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    tx_valid_d = 1'b0;
    tx_data_d  = '0;
    unique case (1'b1)
      (state_d == ST_SEND_HI): begin
        tx_valid_d = 1'b1;
        tx_data_d  = sample_d[SPLIT_W-1 -: BYTE_W];
      end
      (state_d == ST_SEND_LO): begin
        tx_valid_d = 1'b1;
        tx_data_d  = sample_q[BYTE_W-1:0];
      end
      default: begin
        tx_valid_d = 1'b0;
        tx_data_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      sample_q   <= '0;
      mem_rd_q   <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sample_q   <= sample_d;
      mem_rd_q   <= mem_rd_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_rd_o   = mem_rd_q;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule
